// File: rtl/rca_wb_serializer_if.sv
// Bundle-in / register-write-out bus of the RCA result serializer.
// The master side produces bundles and grants the write port; the slave side is the serializer.
interface rca_wb_serializer_if #(
    parameter int NUM_WRITE_PORTS = 5,
    parameter int XLEN            = 32,
    parameter int ID_W            = 3
);
    logic                                  in_done;
    logic [ID_W-1:0]                       in_id;
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  in_rd;
    logic [NUM_WRITE_PORTS-1:0][4:0]       in_rd_addr;
    logic [NUM_WRITE_PORTS-1:0]            in_wr_mask;
    logic                                  in_ready;
    logic                                  rf_we;
    logic [4:0]                            rf_waddr;
    logic [XLEN-1:0]                       rf_wdata;
    logic                                  rf_ready;
    logic                                  cmpl_valid;
    logic [ID_W-1:0]                       cmpl_id;
    logic                                  overflow;

    modport master (
        output in_done, in_id, in_rd, in_rd_addr, in_wr_mask, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata, cmpl_valid, cmpl_id, overflow
    );

    modport slave (
        input  in_done, in_id, in_rd, in_rd_addr, in_wr_mask, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata, cmpl_valid, cmpl_id, overflow
    );
endinterface

// File: rtl/rca_wb_serializer.sv
// Buffers multi-destination result bundles and drains them one register write per cycle,
// then signals completion with the bundle id.
module rca_wb_serializer #(
    parameter int NUM_WRITE_PORTS = 5,
    parameter int XLEN            = 32,
    parameter int ID_W            = 3,
    parameter int DEPTH           = 2
) (
    input logic               clk,
    input logic               rst,
    rca_wb_serializer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SEL_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, CMPL} state_t;

    state_t                     state_q, state_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [NUM_WRITE_PORTS-1:0] pending_q, pending_d;
    logic                       overflow_q, overflow_d;

    logic [ID_W-1:0]                      mem_id_q   [DEPTH];
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] mem_rd_q   [DEPTH];
    logic [NUM_WRITE_PORTS-1:0][4:0]      mem_addr_q [DEPTH];
    logic [NUM_WRITE_PORTS-1:0]           mem_mask_q [DEPTH];

    logic                                 in_ready;
    logic                                 push;
    logic                                 pop;
    logic [ID_W-1:0]                      head_id;
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] head_rd;
    logic [NUM_WRITE_PORTS-1:0][4:0]      head_addr;
    logic [NUM_WRITE_PORTS-1:0]           head_eff;
    logic [NUM_WRITE_PORTS-1:0]           low_bit;
    logic [NUM_WRITE_PORTS-1:0]           pending_next;
    logic [SEL_W-1:0]                     sel_idx;

    logic                                 rf_we;
    logic [4:0]                           rf_waddr;
    logic [XLEN-1:0]                      rf_wdata;
    logic                                 cmpl_valid;
    logic [ID_W-1:0]                      cmpl_id;

    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = bus.in_done && in_ready;
    assign pop      = (state_q == CMPL);

    assign head_id   = mem_id_q[rd_ptr_q];
    assign head_rd   = mem_rd_q[rd_ptr_q];
    assign head_addr = mem_addr_q[rd_ptr_q];

    // Writes to x0 are discarded up front so they never cost a cycle.
    always_comb begin
        head_eff = '0;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            head_eff[i] = mem_mask_q[rd_ptr_q][i] && (head_addr[i] != 5'd0);
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = SEL_W'(i);
            end
        end
    end

    assign low_bit      = pending_q & (~pending_q + NUM_WRITE_PORTS'(1));
    assign pending_next = pending_q & ~low_bit;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (bus.in_done && !in_ready) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pending_d = head_eff;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (pending_q == '0) begin
                    state_d = CMPL;
                end else if (bus.rf_ready) begin
                    pending_d = pending_next;
                    if (pending_next == '0) begin
                        state_d = CMPL;
                    end
                end
            end
            CMPL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        cmpl_valid = 1'b0;
        cmpl_id    = '0;
        if (state_q == WRITE && pending_q != '0) begin
            rf_we    = 1'b1;
            rf_waddr = head_addr[sel_idx];
            rf_wdata = head_rd[sel_idx];
        end
        if (state_q == CMPL) begin
            cmpl_valid = 1'b1;
            cmpl_id    = head_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage needs no reset; only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_id_q[wr_ptr_q]   <= bus.in_id;
            mem_rd_q[wr_ptr_q]   <= bus.in_rd;
            mem_addr_q[wr_ptr_q] <= bus.in_rd_addr;
            mem_mask_q[wr_ptr_q] <= bus.in_wr_mask;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.rf_we      = rf_we;
    assign bus.rf_waddr   = rf_waddr;
    assign bus.rf_wdata   = rf_wdata;
    assign bus.cmpl_valid = cmpl_valid;
    assign bus.cmpl_id    = cmpl_id;
    assign bus.overflow   = overflow_q;
endmodule
